// File: rtl/seq_serializer_if.sv
// Handshake and serial-output bundle between a word producer, the
// serializer and the downstream sequence detector.
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             x;
    logic             x_valid;
    logic             word_done;
    logic             busy;

    // Producer side: drives words, observes flow control and the serial stream.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  x,
        input  x_valid,
        input  word_done,
        input  busy
    );

    // Serializer side.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output x,
        output x_valid,
        output word_done,
        output busy
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the sequence detector. Words are accepted
// into a small circular FIFO and shifted out MSB-first, one bit per clock.
// Between words x holds IDLE_BIT so the detector never sees a spurious match.
module seq_serializer #(
    parameter int   WIDTH    = 8,
    parameter int   DEPTH    = 4,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    seq_serializer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Shifter state. r_shift holds the bits still to be sent after the one
    // currently on x, left-aligned, so x always takes the next MSB.
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [BIT_W-1:0] w_bit_cnt_nxt;

    // Registered outputs and their next values
    logic             r_x;
    logic             r_x_valid;
    logic             r_word_done;
    logic             w_x_nxt;
    logic             w_x_valid_nxt;
    logic             w_word_done_nxt;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic [WIDTH-1:0] w_head;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == {CNT_W{1'b0}});
    assign w_push  = bus.in_valid & ~w_full;
    assign w_head  = r_mem[r_rd_ptr];

    // Next-state and next-output decode for the shifter, including FIFO pops.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_x_nxt         = IDLE_BIT;
        w_x_valid_nxt   = 1'b0;
        w_word_done_nxt = 1'b0;
        w_load          = 1'b0;
        w_pop           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_load = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_bit_cnt == {BIT_W{1'b0}}) begin
                    // Last bit is on x now: chain straight into the next word
                    // if one is waiting, otherwise fall back to idle fill.
                    if (!w_empty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_shift_nxt     = {r_shift[WIDTH-2:0], 1'b0};
                    w_bit_cnt_nxt   = r_bit_cnt - BIT_W'(1);
                    w_x_nxt         = r_shift[WIDTH-1];
                    w_x_valid_nxt   = 1'b1;
                    w_word_done_nxt = (r_bit_cnt == BIT_W'(1));
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_pop           = 1'b1;
            w_state_nxt     = ST_SHIFT;
            w_shift_nxt     = {w_head[WIDTH-2:0], 1'b0};
            w_bit_cnt_nxt   = BIT_W'(WIDTH - 1);
            w_x_nxt         = w_head[WIDTH-1];
            w_x_valid_nxt   = 1'b1;
            w_word_done_nxt = 1'b0;
        end else begin
            w_pop           = 1'b0;
        end
    end

    // Shifter state register and registered serial outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= {WIDTH{1'b0}};
            r_bit_cnt   <= {BIT_W{1'b0}};
            r_x         <= IDLE_BIT;
            r_x_valid   <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_x         <= w_x_nxt;
            r_x_valid   <= w_x_valid_nxt;
            r_word_done <= w_word_done_nxt;
        end
    end

    // FIFO storage: write the incoming word at the write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end else begin
            r_mem <= r_mem;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = ~w_full;
    assign bus.x         = r_x;
    assign bus.x_valid   = r_x_valid;
    assign bus.word_done = r_word_done;
    assign bus.busy      = (r_state == ST_SHIFT) | ~w_empty;
endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer. A cycle-level behavioural model
// (word queue plus a "bits left in the shifter" counter) predicts every
// output each cycle; directed scenarios add stream-level checks.
module tb_seq_serializer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_serializer_if #(.WIDTH(WIDTH)) bus ();

    seq_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_BIT(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] mq [$];
    logic [WIDTH-1:0] m_cur;
    int               m_left;
    logic [3:0]       d_hist;
    bit               last_push;
    int               stall_cnt;

    // Observed stream capture
    logic             cap_q [$];
    int               z_pos [$];
    int               wd_pos [$];
    int               xv_first;
    int               xv_last;
    int               cyc;
    logic [WIDTH-1:0] exp_w [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_left = 0;
        m_cur  = '0;
        d_hist = 4'b1111;
    endtask

    task automatic clear_cap();
        cap_q.delete();
        z_pos.delete();
        wd_pos.delete();
        exp_w.delete();
        xv_first  = -1;
        xv_last   = -1;
        cyc       = 0;
        stall_cnt = 0;
    endtask

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic step();
        logic             push;
        logic [WIDTH-1:0] w;
        logic             e_xv, e_x, e_wd;
        @(posedge clk);
        push = bus.in_valid && (mq.size() < DEPTH);
        w    = bus.in_data;
        if (m_left <= 1 && mq.size() > 0) begin
            m_cur  = mq.pop_front();
            m_left = WIDTH;
        end else if (m_left > 0) begin
            m_left--;
        end
        if (push) mq.push_back(w);
        last_push = push;
        if (bus.in_valid && !push) stall_cnt++;
        e_xv = (m_left > 0);
        e_x  = e_xv ? m_cur[m_left-1] : 1'b1;
        e_wd = (m_left == 1);
        #1;
        check("x_valid",   bus.x_valid,   e_xv);
        check("x",         bus.x,         e_x);
        check("word_done", bus.word_done, e_wd);
        check("in_ready",  bus.in_ready,  (mq.size() < DEPTH));
        check("busy",      bus.busy,      (m_left > 0) || (mq.size() > 0));
        if (bus.x_valid) begin
            if (xv_first < 0) xv_first = cyc;
            xv_last = cyc;
            cap_q.push_back(bus.x);
        end
        if (bus.word_done) wd_pos.push_back(cyc);
        d_hist = {d_hist[2:0], bus.x};
        if (d_hist == 4'b0110) z_pos.push_back(cap_q.size() - 1);
        cyc++;
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        exp_w.push_back(w);
        for (int k = 0; k < 60; k++) begin
            step();
            if (last_push) break;
        end
        check("send_accept", last_push, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (m_left == 0 && mq.size() == 0) break;
            step();
        end
        check("drain_timeout", (m_left == 0 && mq.size() == 0), 1'b1);
        repeat (3) step();
    endtask

    // Compare the captured serial stream against the words sent, MSB first.
    task automatic check_words(input string tag);
        int n;
        n = exp_w.size() * WIDTH;
        check({tag, "_len"}, cap_q.size(), n);
        for (int i = 0; i < n && i < cap_q.size(); i++) begin
            check(tag, cap_q[i], exp_w[i / WIDTH][WIDTH - 1 - (i % WIDTH)]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        reset        = 1'b0;
        model_reset();
        clear_cap();

        // Reset state
        #2 reset = 1'b1;
        #1;
        check("rst_x",         bus.x,         1'b1);
        check("rst_x_valid",   bus.x_valid,   1'b0);
        check("rst_word_done", bus.word_done, 1'b0);
        check("rst_busy",      bus.busy,      1'b0);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle fill: no writes, x stays high and no 0110 is ever seen
        clear_cap();
        repeat (20) step();
        check("idle_valid_bits", cap_q.size(), 0);
        check("idle_z_count",    z_pos.size(), 0);

        // Single word 0x36
        clear_cap();
        send(8'h36);
        drain();
        check_words("single");
        check("single_first_cycle", xv_first, 1);
        check("single_span",        xv_last - xv_first + 1, WIDTH);
        check("single_wd_count",    wd_pos.size(), 1);
        if (wd_pos.size() == 1) check("single_wd_pos", wd_pos[0], xv_last);
        check("single_z_count", z_pos.size(), 2);
        if (z_pos.size() == 2) begin
            check("single_z_bit3", z_pos[0], 4);
            check("single_z_bit0", z_pos[1], 7);
        end

        // Back-to-back words on consecutive edges
        clear_cap();
        send(8'hA5);
        send(8'h0F);
        drain();
        check_words("b2b");
        check("b2b_span",     xv_last - xv_first + 1, 2 * WIDTH);
        check("b2b_wd_count", wd_pos.size(), 2);
        if (wd_pos.size() == 2) check("b2b_wd_gap", wd_pos[1] - wd_pos[0], WIDTH);

        // Full FIFO: six words offered continuously; sixth waits for a pop
        clear_cap();
        send(8'hC1);
        send(8'hC2);
        send(8'hC3);
        send(8'hC4);
        send(8'hC5);
        send(8'hC6);
        check("full_stall_cycles", stall_cnt, 5);
        drain();
        check_words("full");

        // Reset in the middle of a word with two words buffered
        clear_cap();
        send(8'h63);
        send(8'h81);
        send(8'h7E);
        for (int k = 0; k < 40; k++) begin
            if (m_left == 4) break;
            step();
        end
        check("mid_reach_bit3", m_left, 4);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_x",         bus.x,         1'b1);
        check("mid_rst_x_valid",   bus.x_valid,   1'b0);
        check("mid_rst_word_done", bus.word_done, 1'b0);
        check("mid_rst_busy",      bus.busy,      1'b0);
        check("mid_rst_in_ready",  bus.in_ready,  1'b1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_cap();
        repeat (12) step();
        check("mid_no_stale_bits", cap_q.size(), 0);
        send(8'h3C);
        drain();
        check_words("mid_after");

        // Pointer wrap: 3*DEPTH+1 random words with random gaps
        clear_cap();
        for (int n = 0; n < 3 * DEPTH + 1; n++) begin
            repeat ($urandom_range(0, 12)) step();
            send(WIDTH'($urandom));
        end
        drain();
        check_words("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
